// File: rtl/kmap_lut_engine.sv
// kmap_lut_engine
//   Runtime-reprogrammable truth-table evaluator for an N-input boolean
//   function with per-entry don't-care marking and a one-stage registered
//   valid/ready pipeline.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   cfg_we/addr/val/care table entry write (value + care bit)
//   dc_mode             don't-care policy: 0 force 0, 1 force 1,
//                       2 hold last emitted f, 3 hold and flag f_dc
//   in_valid/in_ready/x input vector handshake
//   out_valid/out_ready output handshake
//   f, f_dc             evaluated value, don't-care flag (mode 3 only)
//   cnt_clr, dc_cnt     clear / saturating count of don't-care accepts
//
// state       | meaning
// out_valid=0 | output stage empty, accepts freely
// out_valid=1 | f/f_dc held until out_ready; refilled on same edge if
//             | a new vector is accepted
module kmap_lut_engine #(
  parameter int unsigned N = 4,
  parameter logic [(1<<N)-1:0] RESET_VAL  = 16'h5850,
  parameter logic [(1<<N)-1:0] RESET_CARE = 16'h5BD4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_addr,
  input  logic             cfg_val,
  input  logic             cfg_care,
  input  logic [1:0]       dc_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             f,
  output logic             f_dc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] dc_cnt
);

  localparam int unsigned DEPTH = 1 << N;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DEPTH-1:0] val_q, val_d;
  logic [DEPTH-1:0] care_q, care_d;
  logic             out_valid_q, out_valid_d;
  // f_q doubles as the hold register: both are reset to 0 and both take
  // the new value on every accept, so a separate copy would be redundant.
  logic             f_q, f_d;
  logic             f_dc_q, f_dc_d;
  logic [CNT_W-1:0] dc_cnt_q, dc_cnt_d;

  logic accept;
  logic entry_val, entry_care;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  // Read from the registered table so a same-cycle write is not visible.
  assign entry_val  = val_q[x];
  assign entry_care = care_q[x];

  always_comb begin
    val_d       = val_q;
    care_d      = care_q;
    out_valid_d = out_valid_q;
    f_d         = f_q;
    f_dc_d      = f_dc_q;
    dc_cnt_d    = dc_cnt_q;

    if (cfg_we) begin
      val_d[cfg_addr]  = cfg_val;
      care_d[cfg_addr] = cfg_care;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      f_dc_d      = 1'b0;
      if (entry_care) begin
        f_d = entry_val;
      end else begin
        case (dc_mode)
          2'd0: f_d = 1'b0;
          2'd1: f_d = 1'b1;
          2'd2: f_d = f_q;
          default: begin
            f_d    = f_q;
            f_dc_d = 1'b1;
          end
        endcase
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (cnt_clr) begin
      dc_cnt_d = '0;
    end else if (accept && !entry_care && dc_cnt_q != CNT_MAX) begin
      dc_cnt_d = dc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q       <= RESET_VAL;
      care_q      <= RESET_CARE;
      out_valid_q <= 1'b0;
      f_q         <= 1'b0;
      f_dc_q      <= 1'b0;
      dc_cnt_q    <= '0;
    end else begin
      val_q       <= val_d;
      care_q      <= care_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      f_dc_q      <= f_dc_d;
      dc_cnt_q    <= dc_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign f_dc      = f_dc_q;
  assign dc_cnt    = dc_cnt_q;

endmodule
